// File: rtl/d_mem_arb_pkg.sv
// Shared encodings for the byte-serialising data-memory arbiter.
// Holds the access-size codes, the FSM state type and the last-byte-index helper.
package d_mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the last byte cycle for an access size (11 also counts as a word).
    function automatic logic [1:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/d_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; the last-grant pointer is owned by the parent.
// On a tie the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/d_mem_arbiter.sv
// Shares one byte-wide memory port between the CPU (requester 0) and the debug port (requester 1).
// Granted accesses are split into little-endian byte cycles; reads return zero-extended with done.
module d_mem_arbiter
    import d_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [31:0]       rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [1:0]        dbg_state_o
);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rbuf_q, rbuf_d;
    logic [1:0]          pick;

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_q),
        .grant (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            idx_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            size_q  <= size_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = XFER;
            XFER:    if (idx_q == nbytes(size_q)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching and byte sequencing; nothing outside IDLE looks at the live inputs.
    always_comb begin
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        size_d  = size_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = pick[1];
                    last_d  = pick[1];
                    we_d    = pick[1] ? we[1]  : we[0];
                    size_d  = pick[1] ? size1  : size0;
                    addr_d  = pick[1] ? addr1  : addr0;
                    wdata_d = pick[1] ? wdata1 : wdata0;
                    idx_d   = 2'd0;
                    rbuf_d  = '0;
                end
            end
            XFER: begin
                if (!we_q) begin
                    rbuf_d[{idx_q, 3'b000} +: 8] = mem_rdata;
                end
                idx_d = idx_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt         = '0;
        done        = '0;
        rdata       = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        dbg_state_o = state_q;
        case (state_q)
            IDLE: begin
                // Masked so a requester holding req through reset sees no grant.
                if (rst_n) gnt = pick;
            end
            XFER: begin
                mem_re   = ~we_q;
                mem_we   = we_q;
                mem_addr = addr_q + ADDR_W'(idx_q);
                if (we_q) mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
            end
            DONE: begin
                done = owner_q ? 2'b10 : 2'b01;
                if (!we_q) rdata = rbuf_q;
            end
            default: ;
        endcase
    end

endmodule
